cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 21 ++
 rtl/cdb_rr_picker.sv | 35 +++
 rtl/cdb_arbiter.sv | 85 ++++++++
 tb/tb_cdb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
// Default widths match the reservation-station tag and result formats.
package cdb_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 4;

  typedef struct packed {
    logic                  valid;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_TAG_W-1:0]  tag;
  } cdb_bus_t;

  // Search position k steps past base, wrapping within n sources.
  function automatic int unsigned wrap_inc(input int unsigned base,
                                           input int unsigned k,
                                           input int unsigned n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational picker: scans requests starting one past ptr_i, with wrap-around.
// Returns the first request found as a one-hot grant and as a binary index.
module cdb_rr_picker
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned j;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      j = wrap_inc(int'(ptr_i), k, NUM_SRC);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one functional-unit result per cycle and registers the broadcast.
// The CDB_ARB_RR_EN macro selects round-robin priority; without it the lowest index always wins.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag
);

  localparam int               IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_SRC - 1);

  // Same layout as cdb_bus_t, widened to the instance's parameters.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } bus_t;

  bus_t               cdb_q, cdb_d;
  logic [NUM_SRC-1:0] req, gnt;
  logic [IDX_W-1:0]   ptr, win_idx;
  logic               win_any;

  assign req = src_valid & {NUM_SRC{~flush}};

`ifdef CDB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign ptr_d = win_any ? win_idx : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PTR_RST;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  // Search always begins at source 0, which gives lowest-index priority.
  assign ptr = PTR_RST;
`endif

  cdb_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = win_any;
    if (win_any) begin
      cdb_d.data = src_data[int'(win_idx)*DATA_W +: DATA_W];
      cdb_d.tag  = src_tag[int'(win_idx)*TAG_W +: TAG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cdb_q <= '0;
    else        cdb_q <= cdb_d;
  end

  assign src_ready = gnt;
  assign cdb_valid = cdb_q.valid;
  assign cdb_data  = cdb_q.data;
  assign cdb_tag   = cdb_q.tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vectors on a 6-source instance plus random sweeps at 2 and 16 sources.
// Expected grants come from a scan-based priority model; CDB_ARB_RR_EN selects which priority rule it applies.
module tb_cdb_arbiter;
  import cdb_pkg::*;

`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  // 6-source instance, driven by directed vectors
  logic [5:0]    v6 = '0, r6;
  logic [31:0]   d6[6];
  logic [3:0]    t6[6];
  logic [191:0]  d6f;
  logic [23:0]   t6f;
  logic          cv6;
  logic [31:0]   cd6;
  logic [3:0]    ct6;

  always_comb begin
    d6f = '0;
    t6f = '0;
    for (int i = 0; i < 6; i++) begin
      d6f[i*32 +: 32] = d6[i];
      t6f[i*4 +: 4]   = t6[i];
    end
  end

  // Sweep instances: 2 and 16 sources
  logic [1:0]   v2 = '0, r2;
  logic [15:0]  v16 = '0, r16;
  logic [63:0]  d2f = 64'h2222_0002_2222_0001;
  logic [7:0]   t2f = 8'h21;
  logic [511:0] d16f = '0;
  logic [63:0]  t16f = 64'hFEDC_BA98_7654_3210;
  logic         cv2, cv16;
  logic [31:0]  cd2, cd16;
  logic [3:0]   ct2, ct16;

  cdb_arbiter #(.NUM_SRC(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(v6), .src_data(d6f), .src_tag(t6f),
    .src_ready(r6), .cdb_valid(cv6), .cdb_data(cd6), .cdb_tag(ct6));

  cdb_arbiter #(.NUM_SRC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(v2), .src_data(d2f), .src_tag(t2f),
    .src_ready(r2), .cdb_valid(cv2), .cdb_data(cd2), .cdb_tag(ct2));

  cdb_arbiter #(.NUM_SRC(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(v16), .src_data(d16f), .src_tag(t16f),
    .src_ready(r16), .cdb_valid(cv16), .cdb_data(cd16), .cdb_tag(ct16));

  int compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner for n sources: first valid index after the last grant, wrapping; -1 when nothing is valid.
  function automatic int pick(input logic [15:0] v, input int last, input int n);
    for (int k = 1; k <= n; k++)
      if (v[(last + k) % n]) return (last + k) % n;
    return -1;
  endfunction

  function automatic logic [15:0] onehot(input int g);
    logic [15:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Reference state: last grant per instance and the expected 6-source broadcast
  int       m_ptr6, m_ptr2, m_ptr16;
  cdb_bus_t m6;

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    if (!rst_n) begin
      m_ptr6 <= 5; m_ptr2 <= 1; m_ptr16 <= 15;
      m6 <= '0;
    end else begin
      g = flush ? -1 : pick({10'b0, v6}, m_ptr6, 6);
      if (g < 0) m6.valid <= 1'b0;
      else begin
        m6 <= '{1'b1, d6[g], t6[g]};
        if (RR) m_ptr6 <= g;
      end
      g = flush ? -1 : pick({14'b0, v2}, m_ptr2, 2);
      if (g >= 0 && RR) m_ptr2 <= g;
      g = flush ? -1 : pick(v16, m_ptr16, 16);
      if (g >= 0 && RR) m_ptr16 <= g;
    end
  end

  always @(negedge clk) begin : compare
    int g;
    g = flush ? -1 : pick({10'b0, v6}, m_ptr6, 6);
    chk("ready6", r6, onehot(g));
    chk("cdb_valid6", cv6, m6.valid);
    chk("cdb_data6", cd6, m6.data);
    chk("cdb_tag6", ct6, m6.tag);
    g = flush ? -1 : pick({14'b0, v2}, m_ptr2, 2);
    chk("ready2", r2, onehot(g));
    chk("onehot2", 64'($countones(r2) <= 1), 64'd1);
    g = flush ? -1 : pick(v16, m_ptr16, 16);
    chk("ready16", r16, onehot(g));
    chk("onehot16", 64'($countones(r16) <= 1), 64'd1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic req(input int i, input logic [31:0] d, input logic [3:0] t);
    v6[i] = 1'b1; d6[i] = d; t6[i] = t;
  endtask

  logic [5:0]  exp_first, exp_second;
  logic [31:0] dat_first, dat_second;
  logic [1:0]  g2;
  logic [15:0] g16;
  int          w2[2], w16[16];

  initial begin
    for (int i = 0; i < 6; i++) begin d6[i] = '0; t6[i] = '0; end

    // Reset state
    @(negedge clk);
    chk("rst_valid", cv6, 1'b0);
    chk("rst_data", cd6, 32'h0);
    chk("rst_ready", r6, 6'b0);
    tick();
    rst_n = 1'b1;

    // Single source
    req(2, 32'hDEADBEEF, 4'h3);
    @(negedge clk);
    chk("single_ready", r6, 6'b000100);
    tick();
    v6[2] = 1'b0;
    chk("single_valid", cv6, 1'b1);
    chk("single_tag", ct6, 4'h3);
    chk("single_data", cd6, 32'hDEADBEEF);

    // Asynchronous reset while the broadcast is on the bus
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", cv6, 1'b0);
    chk("async_rst_tag", ct6, 4'h0);
    chk("async_rst_data", cd6, 32'h0);
    tick();
    rst_n = 1'b1;

    // Fairness: all six held valid
    for (int i = 0; i < 6; i++) req(i, 32'h1000_0000 + i, 4'(i));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("fair_ready", r6, RR ? 6'(1 << (c % 6)) : 6'b000001);
      tick();
    end
    v6 = '0;

    // Stall then retire: pointer moved to 1 first
    do_reset();
    req(1, 32'hAAAA_0001, 4'h1);
    tick();
    req(1, 32'hC0DE_0001, 4'h1);
    req(4, 32'h4444_0004, 4'h4);
    exp_first  = RR ? 6'b010000 : 6'b000010;
    exp_second = RR ? 6'b000010 : 6'b010000;
    dat_first  = RR ? 32'h4444_0004 : 32'hC0DE_0001;
    dat_second = RR ? 32'hC0DE_0001 : 32'h4444_0004;
    @(negedge clk);
    chk("stall_first", r6, exp_first);
    tick();
    v6 = v6 & ~exp_first;
    chk("stall_first_data", cd6, dat_first);
    @(negedge clk);
    chk("stall_second", r6, exp_second);
    tick();
    v6 = '0;
    chk("stall_second_data", cd6, dat_second);

    // Flush cancels the grant and leaves the pointer alone
    do_reset();
    req(0, 32'h0F0F_0000, 4'h0);
    req(2, 32'h0F0F_0002, 4'h2);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", r6, 6'b0);
    tick();
    flush = 1'b0;
    chk("flush_valid", cv6, 1'b0);
    @(negedge clk);
    chk("post_flush_ready", r6, 6'b000001);
    tick();
    v6[0] = 1'b0;
    chk("post_flush_data", cd6, 32'h0F0F_0000);
    tick();
    v6 = '0;

    // Random sweep on 2 and 16 sources; each request held until granted
    do_reset();
    for (int i = 0; i < 2; i++) w2[i] = 0;
    for (int i = 0; i < 16; i++) w16[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g2  = v2 & r2;
      g16 = v16 & r16;
      for (int i = 0; i < 2; i++) begin
`ifdef CDB_ARB_RR_EN
        if (g2[i]) chk("latency2", 64'(w2[i] < 2), 64'd1);
`endif
        if (g2[i]) w2[i] = 0; else if (v2[i]) w2[i]++;
      end
      for (int i = 0; i < 16; i++) begin
`ifdef CDB_ARB_RR_EN
        if (g16[i]) chk("latency16", 64'(w16[i] < 16), 64'd1);
`endif
        if (g16[i]) w16[i] = 0; else if (v16[i]) w16[i]++;
      end
      tick();
      v2  = (v2 & ~g2) | 2'($urandom);
      v16 = (v16 & ~g16) | 16'($urandom & $urandom);
    end
    v2 = '0; v16 = '0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
